// File: rtl/tcm_arb_ctrl_pkg.sv
// Shared constants for the TCM arbiter: address map defaults,
// response encoding and the NOP fed to the pipeline on denied fetches.
package tcm_arb_ctrl_pkg;

   localparam logic [31:0] ITCM_BASE_D  = 32'h0000_0000;
   localparam int          ITCM_DEPTH_D = 4096;
   localparam logic [31:0] DTCM_BASE_D  = 32'h1000_0000;
   localparam int          DTCM_DEPTH_D = 4096;
   localparam int          DTCM_BANKS_D = 2;
   localparam int          STARVE_MAX_D = 4;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {
      RESP_OK  = 1'b0,
      RESP_ERR = 1'b1
   } resp_e;

endpackage

// File: rtl/tcm_arb_ctrl_if.sv
// Fetch and load/store req/gnt/rvalid bundle between the core
// pipeline (master) and the TCM controller (slave).
interface tcm_arb_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    if_req_i;
   logic [ADDR_WIDTH-1:0]   if_addr_i;
   logic                    if_gnt_o;
   logic                    if_rvalid_o;
   logic [DATA_WIDTH-1:0]   if_rdata_o;
   logic                    if_err_o;
   logic                    lsu_req_i;
   logic                    lsu_we_i;
   logic [DATA_WIDTH/8-1:0] lsu_be_i;
   logic [ADDR_WIDTH-1:0]   lsu_addr_i;
   logic [DATA_WIDTH-1:0]   lsu_wdata_i;
   logic                    lsu_gnt_o;
   logic                    lsu_rvalid_o;
   logic [DATA_WIDTH-1:0]   lsu_rdata_o;
   logic                    lsu_err_o;
   logic                    hold_flag_o;

   modport master (
      output if_req_i, if_addr_i,
      output lsu_req_i, lsu_we_i, lsu_be_i,
      output lsu_addr_i, lsu_wdata_i,
      input  if_gnt_o, if_rvalid_o,
      input  if_rdata_o, if_err_o,
      input  lsu_gnt_o, lsu_rvalid_o,
      input  lsu_rdata_o, lsu_err_o,
      input  hold_flag_o
   );

   modport slave (
      input  if_req_i, if_addr_i,
      input  lsu_req_i, lsu_we_i, lsu_be_i,
      input  lsu_addr_i, lsu_wdata_i,
      output if_gnt_o, if_rvalid_o,
      output if_rdata_o, if_err_o,
      output lsu_gnt_o, lsu_rvalid_o,
      output lsu_rdata_o, lsu_err_o,
      output hold_flag_o
   );
endinterface

// File: rtl/tcm_arb_ctrl_bank.sv
// tcm_bank: single-port synchronous SRAM, byte-enabled writes,
// registered read data. Contents are intentionally never reset.
module tcm_bank #(
   parameter int DEPTH      = 4096,
   parameter int DATA_WIDTH = 32,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int NB = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [NB-1:0]         be,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < NB; i++) begin
               if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/tcm_arb_ctrl.sv
// IF/LSU arbiter onto one ITCM and a word-interleaved DTCM.
// Define TCM_ARB_PERF_EN to add conflict/starvation counters.
module tcm_arb_ctrl
   import tcm_arb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] ITCM_BASE = ITCM_BASE_D,
   parameter int ITCM_DEPTH = ITCM_DEPTH_D,
   parameter logic [ADDR_WIDTH-1:0] DTCM_BASE = DTCM_BASE_D,
   parameter int DTCM_DEPTH = DTCM_DEPTH_D,
   parameter int DTCM_BANKS = DTCM_BANKS_D,
   parameter int STARVE_MAX = STARVE_MAX_D
) (
   input  logic clk,
   input  logic rst,
`ifdef TCM_ARB_PERF_EN
   output logic [31:0] perf_conflict_o,
   output logic [31:0] perf_starve_o,
`endif
   tcm_arb_ctrl_if.slave bus
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int BB = (NB > 1) ? $clog2(NB) : 0;
   localparam int IW = (ITCM_DEPTH > 1) ? $clog2(ITCM_DEPTH) : 1;
   localparam int DR = DTCM_DEPTH / DTCM_BANKS;
   localparam int RW = (DR > 1) ? $clog2(DR) : 1;
   localparam int KW = (DTCM_BANKS > 1) ? $clog2(DTCM_BANKS) : 1;
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_WIDTH:0] ISIZE = (ADDR_WIDTH+1)'(ITCM_DEPTH * NB);
   localparam logic [ADDR_WIDTH:0] DSIZE = (ADDR_WIDTH+1)'(DTCM_DEPTH * NB);

   logic [ADDR_WIDTH-1:0] if_off, lsu_ioff, lsu_doff, lsu_dw;
   logic                  if_hit, lsu_ihit, lsu_dhit;
   logic [IW-1:0]         if_idx, lsu_iidx;
   logic [KW-1:0]         lsu_bank;
   logic [RW-1:0]         lsu_row;

   assign if_off   = bus.if_addr_i - ITCM_BASE;
   assign lsu_ioff = bus.lsu_addr_i - ITCM_BASE;
   assign lsu_doff = bus.lsu_addr_i - DTCM_BASE;
   assign if_hit   = (bus.if_addr_i >= ITCM_BASE) && ({1'b0, if_off} < ISIZE);
   assign lsu_ihit = (bus.lsu_addr_i >= ITCM_BASE) && ({1'b0, lsu_ioff} < ISIZE);
   assign lsu_dhit = (bus.lsu_addr_i >= DTCM_BASE) && ({1'b0, lsu_doff} < DSIZE);
   assign if_idx   = if_off[BB +: IW];
   assign lsu_iidx = lsu_ioff[BB +: IW];
   assign lsu_dw   = lsu_doff >> BB;
   assign lsu_bank = KW'(lsu_dw % ADDR_WIDTH'(DTCM_BANKS));
   assign lsu_row  = RW'(lsu_dw / ADDR_WIDTH'(DTCM_BANKS));

   logic [CW-1:0] starve_q;
   logic          conflict, force_if, if_gnt, lsu_gnt;

   // Only ITCM is shared; DTCM traffic never blocks a fetch.
   assign conflict = bus.if_req_i & if_hit & bus.lsu_req_i & lsu_ihit;
   assign force_if = (starve_q == CW'(STARVE_MAX));
   assign if_gnt   = bus.if_req_i & ~(conflict & ~force_if);
   assign lsu_gnt  = bus.lsu_req_i & ~(conflict & force_if);

   assign bus.if_gnt_o    = if_gnt;
   assign bus.lsu_gnt_o   = lsu_gnt;
   assign bus.hold_flag_o = bus.if_req_i & ~if_gnt;

   logic                  i_en, i_we;
   logic [NB-1:0]         i_be;
   logic [IW-1:0]         i_addr;
   logic [DATA_WIDTH-1:0] i_rdata;

   always_comb begin
      i_en   = 1'b0;
      i_we   = 1'b0;
      i_be   = '0;
      i_addr = if_idx;
      unique case (1'b1)
         (lsu_gnt & lsu_ihit): begin
            i_en   = 1'b1;
            i_we   = bus.lsu_we_i;
            i_be   = bus.lsu_be_i;
            i_addr = lsu_iidx;
         end
         (if_gnt & if_hit): i_en = 1'b1;
         default: ;
      endcase
   end

   tcm_bank #(.DEPTH(ITCM_DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_itcm (
      .clk   (clk),
      .en    (i_en),
      .we    (i_we),
      .be    (i_be),
      .addr  (i_addr),
      .wdata (bus.lsu_wdata_i),
      .rdata (i_rdata)
   );

   logic [DATA_WIDTH-1:0] d_rdata [DTCM_BANKS];

   for (genvar b = 0; b < DTCM_BANKS; b++) begin : g_dtcm
      tcm_bank #(.DEPTH(DR), .DATA_WIDTH(DATA_WIDTH)) u_bank (
         .clk   (clk),
         .en    (lsu_gnt & lsu_dhit & (lsu_bank == KW'(b))),
         .we    (bus.lsu_we_i),
         .be    (bus.lsu_be_i),
         .addr  (lsu_row),
         .wdata (bus.lsu_wdata_i),
         .rdata (d_rdata[b])
      );
   end

   logic          if_vld_q, lsu_vld_q, lsu_st_q, lsu_dt_q;
   resp_e         if_resp_q, lsu_resp_q;
   logic [KW-1:0] lsu_bk_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_vld_q   <= 1'b0;
         if_resp_q  <= RESP_OK;
         lsu_vld_q  <= 1'b0;
         lsu_resp_q <= RESP_OK;
         lsu_st_q   <= 1'b0;
         lsu_dt_q   <= 1'b0;
         lsu_bk_q   <= '0;
         starve_q   <= '0;
      end else begin
         if_vld_q   <= if_gnt;
         if_resp_q  <= (if_gnt & ~if_hit) ? RESP_ERR : RESP_OK;
         lsu_vld_q  <= lsu_gnt;
         lsu_resp_q <= (lsu_gnt & ~lsu_ihit & ~lsu_dhit) ? RESP_ERR : RESP_OK;
         lsu_st_q   <= bus.lsu_we_i;
         lsu_dt_q   <= lsu_dhit;
         lsu_bk_q   <= lsu_bank;
         if (bus.if_req_i & ~if_gnt) begin
            if (!force_if) starve_q <= starve_q + 1'b1;
         end else begin
            starve_q <= '0;
         end
      end
   end

   logic if_ok, lsu_ok;

   assign if_ok  = if_vld_q & (if_resp_q == RESP_OK);
   assign lsu_ok = lsu_vld_q & (lsu_resp_q == RESP_OK) & ~lsu_st_q;

   assign bus.if_rvalid_o  = if_vld_q;
   assign bus.if_err_o     = if_vld_q & (if_resp_q == RESP_ERR);
   assign bus.if_rdata_o   = if_ok ? i_rdata : '0;
   assign bus.lsu_rvalid_o = lsu_vld_q;
   assign bus.lsu_err_o    = lsu_vld_q & (lsu_resp_q == RESP_ERR);
   assign bus.lsu_rdata_o  = !lsu_ok ? '0 :
                             lsu_dt_q ? d_rdata[lsu_bk_q] : i_rdata;

`ifdef TCM_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_conflict_o <= '0;
         perf_starve_o   <= '0;
      end else begin
         if (conflict) perf_conflict_o <= perf_conflict_o + 32'd1;
         if (conflict & force_if) perf_starve_o <= perf_starve_o + 32'd1;
      end
   end
`endif

endmodule

// File: doc/tcm_arb_ctrl.md
Name: tcm_arb_ctrl

Overview:
- Next-generation tightly-coupled memory controller.
- Arbitrates an instruction-fetch (IF) port and a load/store (LSU) port onto one ITCM and a word-interleaved, multi-bank DTCM.
- Uses a req/gnt/rvalid handshake with registered one-cycle read latency, byte-enabled writes, out-of-range error responses, and a starvation guard for IF.
- Sits between the core pipeline (IF/EX stages) and on-chip SRAM.

Parameters:
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, data width; multiple of 8
- ITCM_BASE, 32'h0000_0000, ITCM byte base address
- ITCM_DEPTH, 4096, ITCM words; power of 2
- DTCM_BASE, 32'h1000_0000, DTCM byte base address
- DTCM_DEPTH, 4096, total DTCM words; power of 2
- DTCM_BANKS, 2, DTCM banks; power of 2, at least 1
- STARVE_MAX, 4, consecutive IF denials before IF is forced priority; at least 1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request
- if_addr_i  in  ADDR_WIDTH  fetch byte address
- if_gnt_o  out  1  fetch accepted this cycle
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DATA_WIDTH  fetched instruction
- if_err_o  out  1  fetch error; qualified by if_rvalid_o
- lsu_req_i  in  1  load/store request
- lsu_we_i  in  1  1 = store
- lsu_be_i  in  DATA_WIDTH/8  byte enables for stores
- lsu_addr_i  in  ADDR_WIDTH  byte address
- lsu_wdata_i  in  DATA_WIDTH  store data
- lsu_gnt_o  out  1  request accepted this cycle
- lsu_rvalid_o  out  1  response valid (loads and stores)
- lsu_rdata_o  out  DATA_WIDTH  load data
- lsu_err_o  out  1  error; qualified by lsu_rvalid_o
- hold_flag_o  out  1  IF request pending but not granted

Behaviour:
- Reset (rst low, asynchronous): all rvalid/err/rdata outputs 0; starvation counter 0; pending responses discarded. Memory contents are not reset.
- Decode: word index = addr >> log2(DATA_WIDTH/8); low byte bits ignored.
  - ITCM hit: ITCM_BASE <= addr < ITCM_BASE + ITCM_DEPTH*bytes.
  - DTCM hit: same rule with DTCM_BASE/DTCM_DEPTH.
  - DTCM bank = word index mod DTCM_BANKS; row = word index / DTCM_BANKS.
  - IF may target ITCM only; an IF address in DTCM or unmapped is an error.
- Grants are combinational, same cycle as the request.
  - A granted request produces rvalid exactly 1 cycle later, with rdata from the registered read.
  - A request not granted must be held stable by the requester until granted.
- Conflict exists only when both ports target ITCM in the same cycle.
  - Default: LSU wins; IF denied; hold_flag_o = 1.
  - When starve_cnt == STARVE_MAX: IF wins; lsu_gnt_o = 0 that cycle.
- starve_cnt:
  - increments (saturating at STARVE_MAX) on if_req_i & !if_gnt_o;
  - clears to 0 on if_gnt_o or !if_req_i.
- LSU to DTCM never conflicts with IF; both are granted in the same cycle.
- Stores: bytes written where lsu_be_i is set; lsu_rvalid_o pulses the next cycle with lsu_rdata_o = 0. A store with be = 0 completes with no write.
- Errors (unmapped address or IF outside ITCM): granted immediately; rvalid + err the next cycle; rdata = 0; no memory access; no store side effect.
- Store followed by a load of the same address in the next cycle returns the new data.
- Back-to-back grants every cycle are supported (full throughput).
- Reset asserted mid-transaction: the in-flight rvalid is suppressed.

Optional Feature:
- Macro: TCM_ARB_PERF_EN.
- Defined:
  - adds output perf_conflict_o [31:0], counting cycles with an ITCM conflict (wraps at 2^32, reset 0);
  - adds output perf_starve_o [31:0], counting forced-IF-priority cycles.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package/defines: address-map constants (ITCM_BASE, DTCM_BASE, depths), the response-error encoding, and the NOP constant 32'h0000_0013 for the pipeline's use on denied fetches.
- One sub-module, tcm_bank: single-port synchronous RAM with byte enables and registered read. Instantiated once for ITCM and DTCM_BANKS times for DTCM.

Test Plan:
- IF-only fetch: IF reads 0x0000_0010 after ITCM preload word[4] = 0xDEAD_BEEF -> if_gnt_o in the same cycle; next cycle if_rvalid_o = 1, if_rdata_o = 0xDEAD_BEEF, if_err_o = 0.
- Parallel access, no conflict: LSU store 0x1000_0004, be = 4'b0011, data 0x1234_5678 over old 0xAAAA_AAAA, in the same cycle as an IF fetch -> both granted; a following load returns 0xAAAA_5678, served from bank 1.
- ITCM contention: LSU holds an ITCM load for 6 cycles while IF also requests -> IF denied for 4 cycles with hold_flag_o = 1; IF granted on the 5th cycle with lsu_gnt_o = 0; LSU granted the next cycle.
- Errors: LSU load 0x2000_0000 -> lsu_gnt_o, then lsu_rvalid_o = 1, lsu_err_o = 1, rdata = 0; IF fetch 0x1000_0000 -> if_err_o = 1.
- Reset mid-flight: rst driven low 0.3 cycle after a grant -> no rvalid; all outputs 0; ITCM contents retained afterwards.
- With TCM_ARB_PERF_EN: the contention scenario gives perf_conflict_o = 5 and perf_starve_o = 1.
